// File: rtl/face_pkg.sv
// Shared types and defaults for the face bounding-box pipeline: image geometry,
// FSM encoding and the min/max/count accumulator record.
package face_pkg;

    localparam int IMG_WIDTH  = 256;
    localparam int IMG_HEIGHT = 256;
    localparam int DEPTH      = 8;
    localparam int COORD_W    = 8;
    localparam int COUNT_W    = 17;
    localparam int MIN_PIXELS = 64;

    typedef logic [COORD_W-1:0] coord_t;
    typedef logic [COUNT_W-1:0] count_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCUM  = 2'd1,
        ST_FINISH = 2'd2
    } state_e;

    typedef struct packed {
        coord_t xmin;
        coord_t xmax;
        coord_t ymin;
        coord_t ymax;
        count_t count;
    } bbox_acc_t;

    // Start-of-frame value: min fields at all-ones so the first face pixel always wins.
    localparam bbox_acc_t ACC_INIT = '{xmin: '1, xmax: '0, ymin: '1, ymax: '0, count: '0};

    function automatic bbox_acc_t acc_update(bbox_acc_t acc, coord_t x, coord_t y);
        bbox_acc_t r;
        r       = acc;
        r.xmin  = (x < acc.xmin) ? x : acc.xmin;
        r.xmax  = (x > acc.xmax) ? x : acc.xmax;
        r.ymin  = (y < acc.ymin) ? y : acc.ymin;
        r.ymax  = (y > acc.ymax) ? y : acc.ymax;
        r.count = acc.count + 1'b1;
        return r;
    endfunction

endpackage

// File: rtl/raster_pos_counter.sv
// Raster x/y position tracker: reports the coordinate of the pixel presented this
// cycle (sof forces 0,0), flags the last pixel of the frame and advances on en_i.
module raster_pos_counter
    import face_pkg::*;
#(
    parameter int WIDTH  = IMG_WIDTH,
    parameter int HEIGHT = IMG_HEIGHT
) (
    input  logic   clk,
    input  logic   rst_n,
    input  logic   en_i,
    input  logic   sof_i,
    output coord_t x_o,
    output coord_t y_o,
    output logic   last_o
);

    coord_t x_q, x_d;
    coord_t y_q, y_d;

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        x_o    = sof_i ? '0 : x_q;
        y_o    = sof_i ? '0 : y_q;
        last_o = (x_o == COORD_W'(WIDTH - 1)) && (y_o == COORD_W'(HEIGHT - 1));
        x_d    = x_q;
        y_d    = y_q;
        if (en_i) begin
            if (x_o == COORD_W'(WIDTH - 1)) begin
                x_d = '0;
                y_d = last_o ? '0 : y_o + 1'b1;
            end else begin
                x_d = x_o + 1'b1;
                y_d = y_o;
            end
        end
    end

    // NOTE: state registers use non-blocking assignments; reset is sampled on the clock edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            x_q <= '0;
            y_q <= '0;
        end else begin
            x_q <= x_d;
            y_q <= y_d;
        end
    end

endmodule

// File: rtl/face_bbox_extract.sv
// Per-frame face bounding box, pixel count and face_found decision computed from a
// raster-order skin-mask stream and the face_reader centroid.
module face_bbox_extract #(
    parameter int IMG_WIDTH  = face_pkg::IMG_WIDTH,
    parameter int IMG_HEIGHT = face_pkg::IMG_HEIGHT,
    parameter int DEPTH      = face_pkg::DEPTH,
    parameter int MIN_PIXELS = face_pkg::MIN_PIXELS
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [DEPTH-1:0]            mask_in,
    input  logic                        mask_valid,
    input  logic                        mask_sof,
    input  logic [face_pkg::COORD_W-1:0] centroid_x,
    input  logic [face_pkg::COORD_W-1:0] centroid_y,
    input  logic                        centroid_valid,
    output logic [face_pkg::COORD_W-1:0] bbox_xmin,
    output logic [face_pkg::COORD_W-1:0] bbox_xmax,
    output logic [face_pkg::COORD_W-1:0] bbox_ymin,
    output logic [face_pkg::COORD_W-1:0] bbox_ymax,
    output logic [face_pkg::COUNT_W-1:0] pix_count,
    output logic                        face_found,
    output logic                        result_valid,
    output logic                        busy
);
    import face_pkg::*;

    if (IMG_WIDTH > 256 || IMG_HEIGHT > 256) begin : g_size_check
        $error("face_bbox_extract: image dimensions exceed 8-bit coordinates");
    end

    state_e    state_q, state_d;
    bbox_acc_t acc_q, acc_d, acc_base;
    bbox_acc_t res_q;
    logic      found_q, found_d;
    logic      result_valid_q;
    logic      accept, start, last_pix, face_pix;
    coord_t    cur_x, cur_y;

    // A sof pixel is taken in IDLE or ACCUM; in ACCUM it abandons the frame in flight.
    assign accept   = mask_valid && ((state_q == ST_ACCUM) || (state_q == ST_IDLE && mask_sof));
    assign start    = accept && mask_sof;
    assign face_pix = |mask_in;

    raster_pos_counter #(
        .WIDTH  (IMG_WIDTH),
        .HEIGHT (IMG_HEIGHT)
    ) u_pos (
        .clk    (clk),
        .rst_n  (rst_n),
        .en_i   (accept),
        .sof_i  (start),
        .x_o    (cur_x),
        .y_o    (cur_y),
        .last_o (last_pix)
    );

    always_comb begin
        acc_base = start ? ACC_INIT : acc_q;
        acc_d    = acc_q;
        if (accept) begin
            acc_d = face_pix ? acc_update(acc_base, cur_x, cur_y) : acc_base;
        end
    end

    assign found_d = (acc_q.count >= COUNT_W'(MIN_PIXELS)) && centroid_valid
                  && (acc_q.xmin <= centroid_x) && (centroid_x <= acc_q.xmax)
                  && (acc_q.ymin <= centroid_y) && (centroid_y <= acc_q.ymax);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (accept) state_d = last_pix ? ST_FINISH : ST_ACCUM;
            ST_ACCUM:  if (accept && last_pix) state_d = ST_FINISH;
            ST_FINISH: state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        busy = (state_q != ST_IDLE);
    end

    // Accumulators are only a few registers, so they are cleared by reset like everything else.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc_q          <= ACC_INIT;
            res_q          <= '0;
            found_q        <= 1'b0;
            result_valid_q <= 1'b0;
        end else begin
            acc_q          <= acc_d;
            result_valid_q <= (state_q == ST_FINISH);
            if (state_q == ST_FINISH) begin
                res_q   <= (acc_q.count == '0) ? '0 : acc_q;
                found_q <= found_d;
            end
        end
    end

    assign bbox_xmin    = res_q.xmin;
    assign bbox_xmax    = res_q.xmax;
    assign bbox_ymin    = res_q.ymin;
    assign bbox_ymax    = res_q.ymax;
    assign pix_count    = res_q.count;
    assign face_found   = found_q;
    assign result_valid = result_valid_q;

endmodule

// File: tb/tb_face_bbox_extract.sv
// Directed bench for face_bbox_extract on a 256x16 image (full 8-bit x range, short frames).
module tb_face_bbox_extract;

    localparam int W    = 256;
    localparam int H    = 16;
    localparam int N    = W * H;
    localparam int MINP = 64;

    localparam int M_EMPTY  = 0;
    localparam int M_SQUARE = 1;
    localparam int M_SINGLE = 2;
    localparam int M_SMALL  = 3;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  mask_in;
    logic        mask_valid, mask_sof;
    logic [7:0]  centroid_x, centroid_y;
    logic        centroid_valid;
    logic [7:0]  bbox_xmin, bbox_xmax, bbox_ymin, bbox_ymax;
    logic [16:0] pix_count;
    logic        face_found, result_valid, busy;

    int n_checks  = 0;
    int n_fail    = 0;
    int rv_pulses = 0;
    int pulses_at;

    face_bbox_extract #(
        .IMG_WIDTH  (W),
        .IMG_HEIGHT (H),
        .DEPTH      (8),
        .MIN_PIXELS (MINP)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .mask_in        (mask_in),
        .mask_valid     (mask_valid),
        .mask_sof       (mask_sof),
        .centroid_x     (centroid_x),
        .centroid_y     (centroid_y),
        .centroid_valid (centroid_valid),
        .bbox_xmin      (bbox_xmin),
        .bbox_xmax      (bbox_xmax),
        .bbox_ymin      (bbox_ymin),
        .bbox_ymax      (bbox_ymax),
        .pix_count      (pix_count),
        .face_found     (face_found),
        .result_valid   (result_valid),
        .busy           (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (result_valid === 1'b1) rv_pulses++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] pix_val(input int mode, input int x, input int y);
        case (mode)
            M_SQUARE: return (x >= 40 && x <= 119 && y >= 3 && y <= 12) ? 8'hFF : 8'h00;
            M_SINGLE: return (x == 255 && y == 15) ? 8'h01 : 8'h00;
            M_SMALL:  return (x <= 7 && y <= 7) ? 8'h80 : 8'h00;
            default:  return 8'h00;
        endcase
    endfunction

    // Presents npix pixels from the frame start; with stall, every third slot is an idle cycle.
    task automatic send_pixels(input int mode, input bit stall, input int npix);
        for (int p = 0; p < npix; p++) begin
            if (stall && (p % 3 == 2)) begin
                mask_valid = 1'b0;
                mask_sof   = 1'b0;
                mask_in    = 8'hFF;
                @(posedge clk); #1;
            end
            mask_valid = 1'b1;
            mask_sof   = (p == 0);
            mask_in    = pix_val(mode, p % W, p / W);
            @(posedge clk); #1;
        end
        mask_valid = 1'b0;
        mask_sof   = 1'b0;
        mask_in    = 8'h00;
    endtask

    // Called #1 after the edge that accepted the last pixel.
    task automatic check_result(input string tag, input int xmin, input int xmax, input int ymin,
                                input int ymax, input int cnt, input int found);
        check({tag, "_rv_early"}, result_valid, 0);
        check({tag, "_busy_fin"}, busy, 1);
        @(posedge clk); #1;
        check({tag, "_rv"},    result_valid, 1);
        check({tag, "_xmin"},  bbox_xmin, xmin);
        check({tag, "_xmax"},  bbox_xmax, xmax);
        check({tag, "_ymin"},  bbox_ymin, ymin);
        check({tag, "_ymax"},  bbox_ymax, ymax);
        check({tag, "_count"}, pix_count, cnt);
        check({tag, "_found"}, face_found, found);
        @(posedge clk); #1;
        check({tag, "_rv_off"},  result_valid, 0);
        check({tag, "_busy_off"}, busy, 0);
        check({tag, "_hold"},    pix_count, cnt);
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_xmin"},  bbox_xmin, 0);
        check({tag, "_xmax"},  bbox_xmax, 0);
        check({tag, "_ymin"},  bbox_ymin, 0);
        check({tag, "_ymax"},  bbox_ymax, 0);
        check({tag, "_count"}, pix_count, 0);
        check({tag, "_found"}, face_found, 0);
        check({tag, "_rv"},    result_valid, 0);
        check({tag, "_busy"},  busy, 0);
    endtask

    initial begin
        rst_n          = 1'b0;
        mask_in        = 8'h00;
        mask_valid     = 1'b0;
        mask_sof       = 1'b0;
        centroid_x     = 8'd80;
        centroid_y     = 8'd7;
        centroid_valid = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_zero_outputs("reset");
        rst_n = 1'b1;

        // Pixels without sof while idle are dropped.
        mask_valid = 1'b1;
        mask_in    = 8'hFF;
        repeat (5) @(posedge clk);
        #1;
        check("idle_drop_busy", busy, 0);
        mask_valid = 1'b0;

        send_pixels(M_EMPTY, 1'b0, N);
        check_result("empty", 0, 0, 0, 0, 0, 0);

        send_pixels(M_SQUARE, 1'b0, N);
        check_result("square", 40, 119, 3, 12, 800, 1);

        centroid_x = 8'd255;
        centroid_y = 8'd15;
        send_pixels(M_SINGLE, 1'b0, N);
        check_result("single", 255, 255, 15, 15, 1, 0);

        // Exactly MIN_PIXELS, centroid on the box corner.
        centroid_x = 8'd0;
        centroid_y = 8'd0;
        send_pixels(M_SMALL, 1'b0, N);
        check_result("minpix", 0, 7, 0, 7, 64, 1);

        centroid_x = 8'd80;
        centroid_y = 8'd7;
        send_pixels(M_SQUARE, 1'b1, N);
        check_result("stall", 40, 119, 3, 12, 800, 1);

        pulses_at = rv_pulses;
        send_pixels(M_SQUARE, 1'b0, 1000);
        send_pixels(M_SQUARE, 1'b0, N);
        check_result("resync", 40, 119, 3, 12, 800, 1);
        check("resync_pulses", rv_pulses - pulses_at, 1);

        pulses_at = rv_pulses;
        send_pixels(M_SQUARE, 1'b0, 2000);
        rst_n      = 1'b0;
        mask_valid = 1'b1;
        mask_in    = 8'hFF;
        @(posedge clk); #1;
        rst_n      = 1'b1;
        mask_valid = 1'b0;
        mask_in    = 8'h00;
        check_zero_outputs("midrst");
        repeat (3) @(posedge clk);
        #1;
        check("midrst_pulses", rv_pulses - pulses_at, 0);
        send_pixels(M_SQUARE, 1'b0, N);
        check_result("after_rst", 40, 119, 3, 12, 800, 1);

        centroid_x = 8'd10;
        centroid_y = 8'd10;
        send_pixels(M_SQUARE, 1'b0, N);
        check_result("cent_out", 40, 119, 3, 12, 800, 0);

        centroid_x     = 8'd80;
        centroid_y     = 8'd7;
        centroid_valid = 1'b0;
        send_pixels(M_SQUARE, 1'b0, N);
        check_result("cent_inval", 40, 119, 3, 12, 800, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
